// File: rtl/mandel_writer_pkg.sv
// rtl/mandel_writer_pkg.sv - shared types and AXI constants for the MandelRISC pixel writer
//
// Purpose: writer FSM state encoding and fixed AXI4-Lite field values.
// Contents:
//   wr_state_t      writer FSM states
//   RESP_OKAY       BRESP value for a successful write
//   AXI_AWPROT      AWPROT driven on every write
//   AXI_WSTRB_FULL  byte strobe for a full 32-bit pixel word
package mandel_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_WAIT_RESP = 2'd2,
      ST_DONE      = 2'd3
   } wr_state_t;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [2:0] AXI_AWPROT     = 3'b000;
   localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

endpackage

// File: rtl/mandel_sync_fifo.sv
// rtl/mandel_sync_fifo.sv - single-clock pointer-based FIFO with a zero-latency head
//
// Purpose: small pixel buffer between the compute core and the AXI writer.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers only)
//   push, din    write side; push into a full FIFO only takes effect with a pop
//   pop, dout    read side; dout is the current head, valid whenever !empty
//   full, empty  occupancy flags
module mandel_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mandel_pixel_writer.sv
// rtl/mandel_pixel_writer.sv - AXI4-Lite single-beat framebuffer writer for MandelRISC pixels
//
// Purpose: buffers per-pixel iteration counts and writes pixel k to frame_base + 4*k,
//          keeping exactly one AXI4-Lite write outstanding at a time.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN        clock, async active-low reset
//   INIT_AXI_TXN                     frame start, rising-edge sensitive
//   frame_base, pixel_count          frame geometry, sampled at start
//   pix_data, pix_valid, pix_ready   pixel stream from the compute core
//   busy, TXN_DONE, ERROR            frame status (ERROR sticky within a frame)
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*    AXI4-Lite write address/data/response channels
module mandel_pixel_writer
   import mandel_writer_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH         = 8,
   parameter int CNT_WIDTH          = 24
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          INIT_AXI_TXN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] frame_base,
   input  logic [CNT_WIDTH-1:0]          pixel_count,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] pix_data,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   output logic                          busy,
   output logic                          TXN_DONE,
   output logic                          ERROR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY
);

   localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;

   wr_state_t                     state;
   wr_state_t                     state_nxt;
   logic                          init_q1;
   logic                          init_q2;
   logic                          start;
   logic                          start_ok;
   logic [ADDR_W-1:0]             base_r;
   logic [CNT_WIDTH-1:0]          count_r;
   logic [CNT_WIDTH-1:0]          accepted;
   logic [CNT_WIDTH-1:0]          written;
   logic                          aw_done;
   logic                          w_done;
   logic                          b_fire;
   logic                          fifo_push;
   logic                          fifo_pop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [C_M_AXI_DATA_WIDTH-1:0] fifo_dout;

   assign start        = init_q1 & ~init_q2;
   assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign busy         = (state == ST_RUN) || (state == ST_WAIT_RESP);
   assign TXN_DONE     = (state == ST_DONE);
   assign M_AXI_AWPROT = AXI_AWPROT;
   assign M_AXI_WSTRB  = AXI_WSTRB_FULL;
   // B is only accepted after both AW and W have been handed off.
   assign M_AXI_BREADY = (state == ST_WAIT_RESP) && aw_done && w_done;
   assign b_fire       = M_AXI_BVALID && M_AXI_BREADY;
   // Stop accepting once the frame's pixel quota has been taken in.
   assign pix_ready    = busy && !fifo_full && (accepted < count_r);
   assign fifo_push    = pix_valid && pix_ready;

   mandel_sync_fifo #(
      .WIDTH (C_M_AXI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (M_AXI_ACLK),
      .rst_n (M_AXI_ARESETN),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (pix_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (written == count_r) begin
               state_nxt = ST_DONE;
            end else if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (b_fire) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         init_q1       <= 1'b0;
         init_q2       <= 1'b0;
         base_r        <= '0;
         count_r       <= '0;
         accepted      <= '0;
         written       <= '0;
         ERROR         <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_WDATA   <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
      end else begin
         init_q1 <= INIT_AXI_TXN;
         init_q2 <= init_q1;

         if (start_ok) begin
            // Word-align the base; the low two address bits are never driven.
            base_r   <= frame_base & ~ADDR_W'(3);
            count_r  <= pixel_count;
            accepted <= '0;
            written  <= '0;
            ERROR    <= 1'b0;
         end else begin
            if (fifo_push) accepted <= accepted + 1'b1;
            if (b_fire) begin
               written <= written + 1'b1;
               if (M_AXI_BRESP != RESP_OKAY) ERROR <= 1'b1;
            end
         end

         if (fifo_pop) begin
            M_AXI_AWADDR  <= base_r + (ADDR_W'(written) << 2);
            M_AXI_WDATA   <= fifo_dout;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
         end else begin
            // AW and W complete independently; each VALID drops after its own handshake.
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               M_AXI_AWVALID <= 1'b0;
               aw_done       <= 1'b1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               M_AXI_WVALID <= 1'b0;
               w_done       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// tb/tb_mandel_pixel_writer.sv - self-checking bench for mandel_pixel_writer
module tb_mandel_pixel_writer;

   localparam int CW = 24;

   logic          tb_ACLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          INIT_AXI_TXN = 1'b0;
   logic [31:0]   frame_base = '0;
   logic [CW-1:0] pixel_count = '0;
   logic [31:0]   pix_data = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic          busy;
   logic          TXN_DONE;
   logic          ERROR;
   logic [31:0]   M_AXI_AWADDR;
   logic [2:0]    M_AXI_AWPROT;
   logic          M_AXI_AWVALID;
   logic          M_AXI_AWREADY = 1'b0;
   logic [31:0]   M_AXI_WDATA;
   logic [3:0]    M_AXI_WSTRB;
   logic          M_AXI_WVALID;
   logic          M_AXI_WREADY = 1'b0;
   logic [1:0]    M_AXI_BRESP = 2'b00;
   logic          M_AXI_BVALID = 1'b0;
   logic          M_AXI_BREADY;

   always #5 tb_ACLK = ~tb_ACLK;

   mandel_pixel_writer #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .FIFO_DEPTH         (4),
      .CNT_WIDTH          (CW)
   ) dut (
      .M_AXI_ACLK    (tb_ACLK),
      .M_AXI_ARESETN (rst_n),
      .INIT_AXI_TXN  (INIT_AXI_TXN),
      .frame_base    (frame_base),
      .pixel_count   (pixel_count),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .busy          (busy),
      .TXN_DONE      (TXN_DONE),
      .ERROR         (ERROR),
      .M_AXI_AWADDR  (M_AXI_AWADDR),
      .M_AXI_AWPROT  (M_AXI_AWPROT),
      .M_AXI_AWVALID (M_AXI_AWVALID),
      .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA   (M_AXI_WDATA),
      .M_AXI_WSTRB   (M_AXI_WSTRB),
      .M_AXI_WVALID  (M_AXI_WVALID),
      .M_AXI_WREADY  (M_AXI_WREADY),
      .M_AXI_BRESP   (M_AXI_BRESP),
      .M_AXI_BVALID  (M_AXI_BVALID),
      .M_AXI_BREADY  (M_AXI_BREADY)
   );

   int checks = 0;
   int errors = 0;

   // Frame configuration, written only by the main sequence.
   int          epoch = 0;
   int          aw_delay = 0, w_delay = 0, b_delay = 0, err_at = -1;
   logic [31:0] pix_arr [64];
   int          pix_n = 0;

   // Slave-side state, owned by the responder process.
   int          s_epoch = 0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_idx = 0;
   bit          aw_got = 0, w_got = 0, aw_seen = 0, w_seen = 0;
   bit          aw_fire = 0, w_fire = 0, b_fire = 0;
   logic [31:0] aw_hold = '0, w_hold = '0;
   int          stab_err = 0, proto_err = 0, w_before_aw = 0, aw_total = 0;
   logic [31:0] got_addr [$];
   logic [31:0] got_data [$];

   // Producer-side state, owned by the core model.
   int          p_epoch = 0;
   int          pix_idx = 0;
   bit          pix_fire = 0;
   int          bp_cycles = 0;

   // AXI4-Lite slave with programmable AW/W/B latency.
   always @(negedge tb_ACLK) begin
      if (!rst_n) begin
         M_AXI_AWREADY = 1'b0;
         M_AXI_WREADY  = 1'b0;
         M_AXI_BVALID  = 1'b0;
         M_AXI_BRESP   = 2'b00;
         aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0;
         aw_fire = 0; w_fire = 0; b_fire = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
         if (s_epoch != epoch) begin
            s_epoch = epoch;
            got_addr.delete();
            got_data.delete();
            b_idx = 0;
         end
         if (aw_fire) begin aw_got = 1; M_AXI_AWREADY = 1'b0; end
         if (w_fire) begin
            w_got = 1;
            M_AXI_WREADY = 1'b0;
            if (!aw_got) w_before_aw++;
         end
         if (b_fire) begin
            M_AXI_BVALID = 1'b0;
            got_addr.push_back(aw_hold);
            got_data.push_back(w_hold);
            b_idx++;
            aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end
         if (M_AXI_AWVALID && aw_got) proto_err++;
         if (M_AXI_WVALID && w_got) proto_err++;
         if (M_AXI_BREADY && !(aw_got && w_got)) proto_err++;
         if (M_AXI_AWVALID && !aw_got) begin
            if (aw_seen) begin
               if (M_AXI_AWADDR !== aw_hold) stab_err++;
            end else begin
               aw_seen = 1; aw_hold = M_AXI_AWADDR; aw_total++;
            end
            if (aw_cnt >= aw_delay) M_AXI_AWREADY = 1'b1;
            else aw_cnt++;
         end
         if (M_AXI_WVALID && !w_got) begin
            if (w_seen) begin
               if (M_AXI_WDATA !== w_hold) stab_err++;
            end else begin
               w_seen = 1; w_hold = M_AXI_WDATA;
            end
            if (w_cnt >= w_delay) M_AXI_WREADY = 1'b1;
            else w_cnt++;
         end
         if (aw_got && w_got && !M_AXI_BVALID) begin
            if (b_cnt >= b_delay) begin
               M_AXI_BVALID = 1'b1;
               M_AXI_BRESP  = (b_idx == err_at) ? 2'b10 : 2'b00;
            end else begin
               b_cnt++;
            end
         end
         aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
         w_fire  = M_AXI_WVALID && M_AXI_WREADY;
         b_fire  = M_AXI_BVALID && M_AXI_BREADY;
      end
   end

   // Compute-core model: offers pix_arr[0..pix_n-1] in order with random gaps.
   always @(negedge tb_ACLK) begin
      if (p_epoch != epoch) begin
         p_epoch = epoch;
         pix_idx = 0;
         pix_fire = 0;
      end
      if (pix_fire) pix_idx++;
      if (rst_n && pix_idx < pix_n && $urandom_range(0, 3) != 0) begin
         pix_valid = 1'b1;
         pix_data  = pix_arr[pix_idx];
      end else begin
         pix_valid = 1'b0;
         pix_data  = '0;
      end
      pix_fire = rst_n && pix_valid && pix_ready;
      if (busy && !pix_ready && pix_idx < int'(pixel_count)) bp_cycles++;
   end

   task automatic tick();
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) pix_arr[k] = $urandom;
   endtask

   // Runs one frame over pix_arr[0..n+extra-1] and compares against the address/data model.
   task automatic run_frame(input string tag, input logic [31:0] base, input int n,
                            input int extra, input int awd, input int wd, input int bd,
                            input int ea, input bit repulse);
      int          cyc;
      int          stab0, proto0;
      logic [31:0] exp_addr;
      aw_delay = awd; w_delay = wd; b_delay = bd; err_at = ea;
      pix_n = n + extra;
      frame_base = base;
      pixel_count = CW'(n);
      epoch++;
      stab0 = stab_err;
      proto0 = proto_err;
      INIT_AXI_TXN = 1'b1;
      repeat (3) tick();
      INIT_AXI_TXN = 1'b0;
      if (n > 0) begin
         check({tag, "_busy_after_start"}, busy, 1);
         check({tag, "_done_cleared"}, TXN_DONE, 0);
         check({tag, "_error_cleared"}, ERROR, 0);
      end
      if (repulse) begin
         repeat (2) tick();
         check({tag, "_busy_at_repulse"}, busy, 1);
         INIT_AXI_TXN = 1'b1;
         repeat (3) tick();
         INIT_AXI_TXN = 1'b0;
      end
      cyc = 0;
      while (!TXN_DONE && cyc < 3000) begin
         tick();
         cyc++;
      end
      check({tag, "_txn_done"}, TXN_DONE, 1);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_write_count"}, got_addr.size(), n);
      for (int k = 0; k < n; k++) begin
         exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * k);
         if (k < got_addr.size()) begin
            check($sformatf("%s_addr%0d", tag, k), got_addr[k], exp_addr);
            check($sformatf("%s_data%0d", tag, k), got_data[k], pix_arr[k]);
         end
      end
      check({tag, "_error"}, ERROR, (ea >= 0 && ea < n) ? 1 : 0);
      check({tag, "_accepted"}, pix_idx, n);
      check({tag, "_stability"}, stab_err - stab0, 0);
      check({tag, "_protocol"}, proto_err - proto0, 0);
   endtask

   initial begin
      int cyc, wb0, aw0, bp0;
      int n, ea;

      // Reset state
      tick();
      check("rst_awvalid", M_AXI_AWVALID, 0);
      check("rst_wvalid", M_AXI_WVALID, 0);
      check("rst_bready", M_AXI_BREADY, 0);
      check("rst_awaddr", M_AXI_AWADDR, 0);
      check("rst_wdata", M_AXI_WDATA, 0);
      check("rst_awprot", M_AXI_AWPROT, 3'b000);
      check("rst_wstrb", M_AXI_WSTRB, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_done", TXN_DONE, 0);
      check("rst_error", ERROR, 0);
      check("rst_pix_ready", pix_ready, 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic zero-wait frame
      pix_arr[0] = 32'h0101FFFF; pix_arr[1] = 32'hABCD0001;
      pix_arr[2] = 32'hDEAD0011; pix_arr[3] = 32'hBEEF0011;
      run_frame("basic", 32'h4000_0000, 4, 0, 0, 0, 0, -1, 0);

      // AWREADY delayed, WREADY immediate: W must complete first every time
      wb0 = w_before_aw;
      fill_random(2);
      run_frame("skew", 32'h0000_2000, 2, 0, 3, 0, 0, -1, 0);
      check("skew_w_first", w_before_aw - wb0, 2);

      // Slow B with a full FIFO exerts backpressure on the core
      bp0 = bp_cycles;
      fill_random(8);
      run_frame("bp", 32'h0000_0000, 8, 0, 0, 0, 10, -1, 0);
      check("bp_ready_dropped", (bp_cycles - bp0) > 0, 1);

      // SLVERR on the second write; frame still completes
      fill_random(3);
      run_frame("err", 32'h8000_0100, 3, 0, 1, 0, 2, 1, 0);
      fill_random(2);
      run_frame("err_clear", 32'h8000_0200, 2, 0, 0, 1, 0, -1, 0);

      // Zero-length frame
      aw0 = aw_total;
      pix_n = 0;
      pixel_count = '0;
      frame_base = 32'h1234_5678;
      epoch++;
      INIT_AXI_TXN = 1'b1;
      tick();
      tick();
      check("zero_busy", busy, 1);
      check("zero_done_low", TXN_DONE, 0);
      tick();
      INIT_AXI_TXN = 1'b0;
      check("zero_done", TXN_DONE, 1);
      check("zero_idle", busy, 0);
      repeat (3) tick();
      check("zero_no_aw", aw_total - aw0, 0);

      // Start re-pulsed mid-frame is ignored
      fill_random(4);
      run_frame("repulse", 32'h0001_0000, 4, 0, 0, 0, 6, -1, 1);

      // Address wrap and extra pixels beyond pixel_count
      fill_random(6);
      run_frame("wrap", 32'hFFFF_FFF9, 4, 2, 1, 2, 1, -1, 0);

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 9);
         ea = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1;
         fill_random(n + 2);
         run_frame($sformatf("rnd%0d", f), $urandom, n, $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), ea, 0);
      end

      // Reset during WAIT_RESP abandons the write
      fill_random(2);
      aw_delay = 0; w_delay = 0; b_delay = 20; err_at = -1;
      pix_n = 2;
      pixel_count = CW'(2);
      frame_base = 32'h0000_1000;
      epoch++;
      INIT_AXI_TXN = 1'b1;
      repeat (3) tick();
      INIT_AXI_TXN = 1'b0;
      cyc = 0;
      while (!M_AXI_BREADY && cyc < 200) begin
         tick();
         cyc++;
      end
      check("rstw_bready_seen", M_AXI_BREADY, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_awvalid", M_AXI_AWVALID, 0);
      check("rstw_wvalid", M_AXI_WVALID, 0);
      check("rstw_bready", M_AXI_BREADY, 0);
      check("rstw_busy", busy, 0);
      check("rstw_pix_ready", pix_ready, 0);
      check("rstw_done", TXN_DONE, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      fill_random(1);
      run_frame("post_rst", 32'h0000_3000, 1, 0, 0, 0, 0, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mandel_pixel_writer.md
Name: mandel_pixel_writer

Overview:
- AXI4-Lite write-only master directly downstream of the MandelRISC compute core.
- Buffers per-pixel iteration results in a small FIFO and writes each one as a single 32-bit AXI4-Lite write to a framebuffer.
- Pixel k goes to address frame_base + 4*k.
- Provides the INIT_AXI_TXN / TXN_DONE / ERROR handshake that the IP top exports on its M00_AXI side.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; pixel word width; only 32 supported.
- FIFO_DEPTH, 8, pixel buffer entries; power of two, minimum 2.
- CNT_WIDTH, 24, width of pixel_count and internal pixel counters.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  frame start; rising-edge sensitive.
- frame_base  in  32  byte address of pixel 0; sampled at start; bits[1:0] ignored (forced 0).
- pixel_count  in  CNT_WIDTH  pixels in frame; sampled at start.
- pix_data  in  32  iteration count from core.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  writer accepts pix_data.
- busy  out  1  frame in progress.
- TXN_DONE  out  1  frame complete; level, held until next start.
- ERROR  out  1  sticky: any BRESP != OKAY in current frame.
- M_AXI_AWADDR  out  32  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  address valid.
- M_AXI_AWREADY  in  1  address accepted.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1  data valid.
- M_AXI_WREADY  in  1  data accepted.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  response valid.
- M_AXI_BREADY  out  1  response accept.

Behaviour:
- Reset state:
  - All outputs 0 except constants (AWPROT = 0, WSTRB = 4'hF).
  - FIFO empty; FSM in IDLE.
  - Reset is asynchronous; asserting it mid-transaction abandons the transfer immediately.
- Start detection:
  - INIT_AXI_TXN passes through two flops; start = q1 & ~q2.
  - Start is a one-cycle pulse, two cycles after the input rises.
  - Start in IDLE or DONE: latch frame_base and pixel_count; clear ERROR, TXN_DONE, accepted count and written count; go to RUN.
  - Start while busy: ignored.
- FSM states: IDLE, RUN, WAIT_RESP, DONE.
  - RUN, written == pixel_count: go to DONE. A pixel_count of 0 reaches DONE one cycle after start.
  - RUN, FIFO non-empty: pop head; drive AWADDR = base + (written << 2) and WDATA = head; assert AWVALID and WVALID in the same cycle; go to WAIT_RESP.
  - WAIT_RESP, AW/W: each VALID drops independently in the cycle after its own READY handshake. Both may complete in the same cycle, in either order, or AW after W.
  - WAIT_RESP, B: BREADY is high once both handshakes are done.
  - WAIT_RESP, on BVALID & BREADY: written++; ERROR |= (BRESP != 2'b00); return to RUN.
  - DONE: TXN_DONE = 1, busy = 0; hold until the next start.
- Outstanding transactions: exactly one. A new AW is never issued before B completes.
- AXI stability: AWADDR, WDATA, AWVALID and WVALID are stable while VALID && !READY.
- Ingress:
  - pix_ready = busy && !fifo_full && (accepted < pixel_count).
  - Push on pix_valid & pix_ready; accepted++.
  - Pixels beyond pixel_count are never accepted.
  - Simultaneous push and pop in one cycle is legal. Occupancy stays the same; a push into a full FIFO is permitted only when a pop happens in the same cycle.
- Busy: busy = 1 in RUN and WAIT_RESP.
- Address arithmetic: 32-bit wrap-around modulo 2^32; no error is flagged on wrap.
- Throughput: at most one pixel per 3 cycles when AWREADY, WREADY and BVALID respond immediately.

Decomposition:
- Package mandel_writer_pkg:
  - FSM state enum.
  - RESP_OKAY = 2'b00.
  - AXI constants: AWPROT value, full WSTRB.
- Sub-module mandel_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointer-based implementation; dout is the head, readable without latency.
- The writer FSM and counters live in the top module.

Test Plan:
- Basic frame: base 0x4000_0000, count 4, pixels 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011, slave with zero wait states -> writes to 0x40000000, 0x04, 0x08, 0x0C with that data in order; TXN_DONE = 1; ERROR = 0.
- Handshake skew: AWREADY delayed 3 cycles, WREADY immediate, count 2 -> WVALID drops first; AWADDR and WDATA stable while pending; exactly 2 B handshakes.
- Backpressure: slave BVALID delayed 10 cycles, core streams 8 pixels, FIFO_DEPTH 4 -> pix_ready drops while the FIFO is full; no pixel lost or duplicated; addresses 0x00 to 0x1C.
- Error: BRESP = 2'b10 on the 2nd of 3 writes -> all 3 writes still issued; ERROR = 1 at DONE; ERROR cleared on the next start.
- Corner cases:
  - pixel_count 0 -> TXN_DONE one cycle after start; no AWVALID.
  - INIT_AXI_TXN re-pulsed mid-frame -> ignored.
- Reset during WAIT_RESP -> all VALID/READY outputs 0 immediately; after release, a new start for count 1 completes normally.
